snn_current_scheduler: RTL and testbench

SNN_CURRENT_SCHEDULER -- requirements
Module: snn_current_scheduler

---
 rtl/snn_current_scheduler_pkg.sv | 26 ++
 rtl/snn_current_scheduler_weighted_sum.sv | 39 +++
 rtl/snn_current_scheduler.sv | 98 +++++++++
 tb/tb_snn_current_scheduler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/snn_current_scheduler_pkg.sv
// Shared types and constants for the SNN input-current scheduler.
// Holds the FSM encoding, datapath widths and the saturation helper.
package snn_current_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CUR_W   = 8;
  localparam int ACC_W   = 13;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Clamp a signed accumulator value into the signed 8-bit current range.
  function automatic logic [CUR_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic [CUR_W-1:0] res;
    if (acc > SAT_MAX)       res = CUR_W'(SAT_MAX);
    else if (acc < SAT_MIN)  res = CUR_W'(SAT_MIN);
    else                     res = acc[CUR_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/snn_current_scheduler_weighted_sum.sv
// Registered spike-gated weight adder: sums the weights whose spike bit is set
// and stores the saturated 8-bit result when en is high.
module snn_weighted_sum_unit
  import snn_current_scheduler_pkg::*;
#(
  parameter int M = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [M-1:0]       spikes,
  input  logic [M*CUR_W-1:0] weights,
  output logic [CUR_W-1:0]   sum
);

  logic signed [ACC_W-1:0] w_acc;
  logic [CUR_W-1:0]        r_sum;

  // 13 bits covers 24 * (+/-128) without wrap before saturation.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < M; i++) begin
      if (spikes[i]) begin
        w_acc = w_acc + {{(ACC_W-CUR_W){weights[i*CUR_W+CUR_W-1]}}, weights[i*CUR_W +: CUR_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= saturate(w_acc);
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/snn_current_scheduler.sv
// Time-multiplexed input-current computation for N neurons using one shared
// weighted-sum unit; one CALC/WRITE pair per neuron, then a DONE pulse.
module snn_current_scheduler
  import snn_current_scheduler_pkg::*;
#(
  parameter int M = 24,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M-1:0]         input_spikes,
  input  logic [N*M*CUR_W-1:0] weights,
  output logic [N*CUR_W-1:0]   currents,
  output logic                 busy,
  output logic                 done,
  output state_t               o_dbg_state
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic [M-1:0]       r_spikes;
  logic [CUR_W-1:0]   r_currents [N];
  logic               r_busy;
  logic               r_done;

  logic               w_en;
  logic [M*CUR_W-1:0] w_nrn_weights;
  logic [CUR_W-1:0]   w_sum;

  assign w_en          = (r_state == S_CALC);
  assign w_nrn_weights = weights[int'(r_index)*M*CUR_W +: M*CUR_W];

  snn_weighted_sum_unit #(.M(M)) u_sum (
    .clk     (clk),
    .reset   (reset),
    .en      (w_en),
    .spikes  (r_spikes),
    .weights (w_nrn_weights),
    .sum     (w_sum)
  );

  // start is only looked at in IDLE, so requests during a sweep are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_index  <= '0;
      r_spikes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int n = 0; n < N; n++) r_currents[n] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spikes <= input_spikes;
            r_index  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_currents[r_index] <= w_sum;
          if (r_index == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cur
    assign currents[g*CUR_W +: CUR_W] = r_currents[g];
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_snn_current_scheduler.sv
// Directed bench for snn_current_scheduler: hand-computed sweep results,
// per-cycle busy/done timing, start-while-busy and mid-sweep reset.
module tb_snn_current_scheduler;
  import snn_current_scheduler_pkg::*;

  localparam int M = 24;
  localparam int N = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [M-1:0]       input_spikes;
  logic [N*M*8-1:0]   weights;
  logic [N*8-1:0]     currents;
  logic               busy;
  logic               done;
  state_t             dbg_state;

  int n_vec = 0;
  int n_err = 0;

  snn_current_scheduler #(.M(M), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .input_spikes (input_spikes),
    .weights      (weights),
    .currents     (currents),
    .busy         (busy),
    .done         (done),
    .o_dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slots(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] srest);
    logic [7:0] e;
    for (int n = 0; n < N; n++) begin
      e = (n == 0) ? s0 : (n == 1) ? s1 : (n == 2) ? s2 : srest;
      check($sformatf("%s slot%0d", tag, n), 32'(currents[n*8 +: 8]), 32'(e));
    end
  endtask

  task automatic set_weight(input int n, input int i, input logic [7:0] v);
    weights[(n*M+i)*8 +: 8] = v;
  endtask

  // Accept edge counts as cycle 0; done must appear exactly in cycle 17 and
  // busy must be high on cycles 1..17. disturb>0 toggles spikes and re-pulses
  // start in that cycle and checks slot 7 still holds hold7.
  task automatic sweep(input string tag, input logic [M-1:0] spk, input int disturb,
                       input logic [7:0] hold7);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    input_spikes = spk;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (disturb > 0 && c == disturb) begin
        check($sformatf("%s mid slot7 hold", tag), 32'(currents[7*8 +: 8]), 32'(hold7));
        input_spikes = ~spk;
        start = 1'b1;
      end
      if (disturb > 0 && c == disturb + 1) start = 1'b0;
      if (done) done_cnt++;
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= 17));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 17));
    end
    check($sformatf("%s done count", tag), 32'(done_cnt), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    input_spikes = '0;
    weights = '0;
    for (int n = 0; n < N; n++)
      for (int i = 0; i < M; i++) set_weight(n, i, 8'd1);
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset state", 32'(dbg_state), 32'(S_IDLE));
    check_slots("reset", 8'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b0;

    // All weights 1, all spikes -> 24 everywhere.
    sweep("ones", {M{1'b1}}, 0, 8'd0);
    check_slots("ones", 8'd24, 8'd24, 8'd24, 8'd24);
    check("ones state idle", 32'(dbg_state), 32'(S_IDLE));

    for (int i = 0; i < M; i++) begin
      set_weight(0, i, 8'd100);
      set_weight(1, i, 8'h9C);
      set_weight(2, i, (i % 2 == 0) ? 8'd5 : 8'hFD);
    end

    // Two spikes: 200 -> 127, -200 -> -128, 5-3 = 2, others 2.
    sweep("sat", 24'h000003, 0, 8'd0);
    check_slots("sat", 8'h7F, 8'h80, 8'd2, 8'd2);

    // All spikes: alternating +5/-3 gives 12*5 - 12*3 = 24.
    sweep("alt", {M{1'b1}}, 0, 8'd0);
    check_slots("alt", 8'h7F, 8'h80, 8'd24, 8'd24);

    // Slots hold while idle even as inputs move.
    input_spikes = 24'h5A5A5A;
    repeat (4) @(negedge clk);
    check_slots("hold", 8'h7F, 8'h80, 8'd24, 8'd24);

    // Four spikes latched; spike toggle and start at cycle 5 must be ignored.
    sweep("busy_start", 24'h00000F, 5, 8'd24);
    check_slots("busy_start", 8'h7F, 8'h80, 8'd4, 8'd4);

    // Reset at cycle 8 of a sweep aborts it with no done pulse.
    @(negedge clk);
    input_spikes = {M{1'b1}};
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    check("mid reset state", 32'(dbg_state), 32'(S_IDLE));
    check_slots("mid reset", 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int late_done;
      late_done = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) late_done++;
      end
      check("post reset no done", 32'(late_done), 32'd0);
      check("post reset busy", 32'(busy), 32'd0);
    end

    sweep("after_reset", 24'h000003, 0, 8'd0);
    check_slots("after_reset", 8'h7F, 8'h80, 8'd2, 8'd2);

    // Zero spikes after a nonzero sweep clear every slot.
    sweep("zero", '0, 0, 8'd0);
    check_slots("zero", 8'd0, 8'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
